// File: rtl/soc_dbg_dump_pkg.sv
// Shared definitions for the run-control / register-dump unit:
// state encoding and the width helpers for the index and cycle counters.
package soc_dbg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_READ = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Register index width; a single-register file still needs a 1-bit index.
    function automatic int idx_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Cycle counter width; must hold RUN_CYCLES itself, at least 1 bit.
    function automatic int cnt_width(input int run_cycles);
        return (run_cycles > 0) ? $clog2(run_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/soc_dbg_dump.sv
// Run-control and register-dump unit. Runs the CPU for a bounded number of
// cycles after a start pulse (or until stop), then freezes it and streams the
// architectural registers out one beat at a time.
//
// Dump port handshake: a beat transfers on a rising clk edge where
// dump_valid && dump_ready. While dump_valid is high and the beat has not
// transferred, dump_data, dump_idx and dump_last do not change. dump_valid
// never depends combinationally on dump_ready.
module soc_dbg_dump
    import soc_dbg_dump_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int RUN_CYCLES = 400,
    parameter int SKIP_X0    = 1,
    localparam int IW        = idx_width(NREGS),
    localparam int CW        = cnt_width(RUN_CYCLES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    output logic            cpu_run,
    output logic [IW-1:0]   reg_addr,
    input  logic [XLEN-1:0] reg_rdata,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [XLEN-1:0] dump_data,
    output logic [IW-1:0]   dump_idx,
    output logic            dump_last,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   cycle_count,
    output logic [2:0]      dbg_state
);

    localparam logic [IW-1:0] START_IDX = (SKIP_X0 != 0 && NREGS > 1) ? IW'(1) : IW'(0);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREGS - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_d;
    logic [CW-1:0]     cnt_d;
    logic [XLEN-1:0]   data_d;

    // Read address is only driven while reading; zero otherwise.
    assign reg_addr  = (state_q == ST_READ) ? dump_idx : '0;
    assign dbg_state = state_q;

    // Next-state, counter and capture logic.
    always_comb begin
        state_d = state_q;
        idx_d   = dump_idx;
        cnt_d   = cycle_count;
        data_d  = dump_data;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d   = '0;
                    idx_d   = START_IDX;
                    state_d = (RUN_CYCLES == 0) ? ST_READ : ST_RUN;
                end
            end
            ST_RUN: begin
                // The cycle in which stop is seen still counts as a run cycle.
                cnt_d = cycle_count + CW'(1);
                if (cycle_count == RUN_LAST || stop) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                data_d  = reg_rdata;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (dump_ready) begin
                    if (dump_idx == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = dump_idx + IW'(1);
                        state_d = ST_READ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dump_idx    <= '0;
            cycle_count <= '0;
            dump_data   <= '0;
            cpu_run     <= 1'b0;
            dump_valid  <= 1'b0;
            dump_last   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dump_idx    <= idx_d;
            cycle_count <= cnt_d;
            dump_data   <= data_d;
            cpu_run     <= (state_d == ST_RUN);
            dump_valid  <= (state_d == ST_SEND);
            dump_last   <= (state_d == ST_SEND) && (idx_d == LAST_IDX);
            busy        <= (state_d == ST_RUN) || (state_d == ST_READ) || (state_d == ST_SEND);
            done        <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_soc_dbg_dump.sv
// Bench for soc_dbg_dump: a default-parameter instance and a small
// zero-budget instance, with an expected-beat queue per instance.
module tb_soc_dbg_dump;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RUNC  = 400;
    localparam int IW    = 5;
    localparam int CW    = 9;
    localparam int IW0   = 2;
    localparam int CW0   = 1;
    localparam int W     = XLEN + IW + 1;
    localparam int W0    = XLEN + IW0 + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n = 1'b0;

    // ---------------- default instance ----------------
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic              dump_ready = 1'b1;
    logic              cpu_run, dump_valid, dump_last, busy, done;
    logic [IW-1:0]     reg_addr, dump_idx;
    logic [XLEN-1:0]   reg_rdata, dump_data;
    logic [CW-1:0]     cycle_count;
    logic [2:0]        dbg_state;
    logic [XLEN-1:0]   rf [NREGS];

    assign reg_rdata = rf[reg_addr];

    soc_dbg_dump dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cpu_run(cpu_run), .reg_addr(reg_addr), .reg_rdata(reg_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_idx(dump_idx), .dump_last(dump_last), .busy(busy), .done(done),
        .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    // ---------------- zero-budget instance ----------------
    logic              start0 = 1'b0;
    logic              dump_ready0;
    logic              cpu_run0, dump_valid0, dump_last0, busy0, done0;
    logic [IW0-1:0]    reg_addr0, dump_idx0;
    logic [XLEN-1:0]   reg_rdata0, dump_data0;
    logic [CW0-1:0]    cycle_count0;
    logic [2:0]        dbg_state0;
    logic [XLEN-1:0]   rf0 [4];

    assign dump_ready0 = 1'b1;
    assign reg_rdata0  = rf0[reg_addr0];

    soc_dbg_dump #(.XLEN(XLEN), .NREGS(4), .RUN_CYCLES(0), .SKIP_X0(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stop(1'b0),
        .cpu_run(cpu_run0), .reg_addr(reg_addr0), .reg_rdata(reg_rdata0),
        .dump_valid(dump_valid0), .dump_ready(dump_ready0), .dump_data(dump_data0),
        .dump_idx(dump_idx0), .dump_last(dump_last0), .busy(busy0), .done(done0),
        .cycle_count(cycle_count0), .dbg_state(dbg_state0)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q [$];
    logic [W0-1:0] exp0_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    int run_len, run_first, run_last, run0_len;
    int first_valid_cyc, last_hs_cyc;
    bit spacing_on = 1'b0;
    bit rdy_rand   = 1'b0;
    bit rdy_val    = 1'b1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Sink ready: changes just after each rising edge, so it is stable for
    // both the monitor (falling edge) and the DUT (next rising edge).
    always @(posedge clk) begin
        #2;
        dump_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    // Count cycles in which the CPU was allowed to advance.
    always @(negedge clk) begin
        if (cpu_run) begin
            run_len++;
            if (run_first < 0) run_first = cyc;
            run_last = cyc;
        end
        if (cpu_run0) run0_len++;
    end

    // Monitor for the default instance: compares beats at each handshake and
    // checks that a stalled beat holds its payload.
    logic [W-1:0]    e;
    bit              stalled = 1'b0;
    logic [XLEN-1:0] hold_data;
    logic [IW-1:0]   hold_idx;
    always @(negedge clk) begin
        if (dump_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled) begin
                check("hold_data", dump_data, hold_data);
                check("hold_idx", dump_idx, hold_idx);
            end
            if (dump_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_idx", dump_idx, e[W-1 -: IW]);
                    check("beat_data", dump_data, e[XLEN:1]);
                    check("beat_last", dump_last, e[0]);
                end
                if (spacing_on && last_hs_cyc >= 0) check("beat_spacing", cyc - last_hs_cyc, 2);
                last_hs_cyc = cyc;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                hold_data = dump_data;
                hold_idx  = dump_idx;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Monitor for the zero-budget instance (sink always ready).
    logic [W0-1:0] e0;
    always @(negedge clk) begin
        if (dump_valid0) begin
            if (exp0_q.size() == 0) begin
                check("unexpected_beat0", 1, 0);
            end else begin
                e0 = exp0_q.pop_front();
                check("beat0_idx", dump_idx0, e0[W0-1 -: IW0]);
                check("beat0_data", dump_data0, e0[XLEN:1]);
                check("beat0_last", dump_last0, e0[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Clears run bookkeeping and queues the whole expected dump from the
    // register file snapshot: indices 1..NREGS-1, last flag on the final one.
    task automatic prep_run();
        run_len = 0; run_first = -1; run_last = -1;
        first_valid_cyc = -1; last_hs_cyc = -1;
        for (int i = 1; i < NREGS; i++) begin
            exp_q.push_back({IW'(i), rf[i], (i == NREGS - 1)});
        end
    endtask

    // Pulses start for one cycle; k is the edge that samples it. Returns at
    // the falling edge just after edge k.
    task automatic run_start(output int k);
        @(negedge clk);
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int rise);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
        rise = cyc;
    endtask

    task automatic preload_rf();
        for (int i = 0; i < NREGS; i++) rf[i] = XLEN'(i) * 32'h0101_0101;
    endtask

    // ---------------- main sequence ----------------
    int k, rise, n;

    initial begin
        preload_rf();
        for (int i = 0; i < 4; i++) rf0[i] = 32'hA5A5_0000 + XLEN'(i * 17);
        run_len = 0; run_first = -1; run_last = -1; run0_len = 0;
        first_valid_cyc = -1; last_hs_cyc = -1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_valid", dump_valid, 0);
        check("rst_last", dump_last, 0);
        check("rst_idx", dump_idx, 0);
        check("rst_data", dump_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", cycle_count, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_state", dbg_state, 0);
        check("rst0_outs", {done0, busy0, dump_valid0, cpu_run0}, 0);
        rst_n = 1'b1;

        // Full run with sink always ready
        spacing_on = 1'b1;
        prep_run();
        wait_until(4);
        run_start(k);
        check("run_busy", busy, 1);
        wait_done(RUNC + 200, rise);
        check("run_len", run_len, RUNC);
        check("run_first", run_first, k);
        check("run_last", run_last, k + RUNC - 1);
        check("first_beat_cyc", first_valid_cyc, k + RUNC + 1);
        check("done_rise", rise, last_hs_cyc + 1);
        check("count_full", cycle_count, RUNC);
        check("busy_after", busy, 0);
        check("cpu_run_after", cpu_run, 0);
        check("queue_empty1", exp_q.size(), 0);

        // Early stop in the 37th run cycle, with an ignored start during RUN
        prep_run();
        run_start(k);
        wait_until(k + 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 36);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(RUNC, rise);
        check("stop_run_len", run_len, 37);
        check("stop_run_last", run_last, k + 36);
        check("stop_first_beat", first_valid_cyc, k + 38);
        check("stop_count", cycle_count, 37);
        check("queue_empty2", exp_q.size(), 0);
        spacing_on = 1'b0;

        // Random register contents, random backpressure, start during SEND
        for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
        rdy_rand = 1'b1;
        prep_run();
        run_start(k);
        n = 0;
        while (!dump_valid && n < RUNC + 50) begin
            @(negedge clk);
            n++;
        end
        if (!dump_valid) check("send_timeout", 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4000, rise);
        check("bp_count", cycle_count, RUNC);
        check("bp_run_len", run_len, RUNC);
        check("queue_empty3", exp_q.size(), 0);
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;

        // Restart from DONE, then reset while beat 9 is stalled
        preload_rf();
        prep_run();
        run_start(k);
        check("restart_count0", cycle_count, 0);
        wait_until(k + 5);
        check("restart_count5", cycle_count, 5);
        n = 0;
        while (!(dbg_state == 3'd2 && reg_addr == IW'(9)) && n < RUNC + 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx9", reg_addr, 9);
        rdy_val = 1'b0;
        @(negedge clk);
        check("stall_valid", dump_valid, 1);
        check("stall_idx", dump_idx, 9);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_outs", {cpu_run, dump_valid, dump_last, busy, done}, 0);
        check("mid_rst_data", dump_data, 0);
        check("mid_rst_idx", dump_idx, 0);
        check("mid_rst_count", cycle_count, 0);
        check("mid_rst_state", dbg_state, 0);
        check("dropped_beats", exp_q.size(), NREGS - 9);
        exp_q.delete();
        rdy_val = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_rst", {dump_valid, busy, done}, 0);

        // Zero cycle budget, register 0 included, four registers
        for (int i = 0; i < 4; i++) exp0_q.push_back({IW0'(i), rf0[i], (i == 3)});
        @(negedge clk);
        start0 = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        check("zero_read_first", dbg_state0, 2);
        check("zero_addr", reg_addr0, 0);
        n = 0;
        while (!done0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("zero_done", done0, 1);
        check("zero_done_cyc", cyc, k + 8);
        check("zero_count", cycle_count0, 0);
        check("zero_cpu_run", run0_len, 0);
        check("queue_empty0", exp0_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
